seq_match_logger: RTL and testbench
===================================

// Module: seq_match_logger
// PURPOSE
//  Downstream consumer of the Mealy overlapping sequence detector's match output z.
//  Tracks the bit position of every serial input bit.
//  On each detection, it pushes the index of the completing bit into a FIFO.
//  A valid/ready port drains the FIFO.
//  Also keeps a saturating total-match count and a sticky overflow flag for status readout.
// PARAMETERS
//  CNT_W    8   width of bit-position index (wraps modulo 2^CNT_W)
//  DEPTH    4   FIFO entries; power of 2, >=2; ADDR_W = $clog2(DEPTH)
//  MATCH_W  16  width of saturating total-match counter
// PORTS
//  clk          in   1          single clock, rising-edge
//  reset        in   1          asynchronous, active-low; all state cleared while low
//  clear        in   1          synchronous flush, active-high
//  bit_en       in   1          qualifies a cycle carrying a valid detector input bit
//  z            in   1          detector match (Mealy output), sampled at posedge
//  evt_ready    in   1          consumer ready
//  evt_valid    out  1          FIFO non-empty
//  evt_pos      out  CNT_W      bit index of oldest logged match (head of FIFO)
//  fill         out  ADDR_W+1   current FIFO occupancy, 0..DEPTH
//  match_total  out  MATCH_W    detections seen since reset/clear, saturating
//  ovf          out  1          sticky: a detection was dropped because FIFO was full
// BEHAVIOUR
//  Reset (reset==0, async)
//   - bit_idx, rd_ptr, wr_ptr, fill, match_total: 0
//   - ovf: 0; evt_valid: 0; evt_pos: 0
//  Bit index
//   - bit_idx increments by 1 on every posedge with bit_en=1; wraps 2^CNT_W-1 -> 0
//   - z is ignored when bit_en=0 (no push, no count)
//  Detection / push, when z&bit_en
//   - push = z&bit_en; pushed value = bit_idx before that edge's increment
//   - Example: 1st bit has idx 0; a match on the 4th bit logs 3
//   - match_total +1 per detection, including dropped ones; holds at 2^MATCH_W-1
//  Pop
//   - pop = evt_valid&evt_ready
//   - evt_pos = mem[rd_ptr] (show-ahead) and is stable while evt_valid&!evt_ready
//  Latency
//   - push at edge N -> evt_valid=1 and evt_pos valid immediately after edge N
//  Boundaries
//   - empty: evt_ready ignored; push+ready same edge -> push only, fill 0->1
//   - full, push, no pop: entry dropped; ovf<=1; fill stays DEPTH; FIFO contents unchanged
//   - full, push & pop same edge: both succeed; fill stays DEPTH; ovf unchanged
//   - non-full push & pop same edge: fill unchanged; FIFO order preserved
//   - pointers wrap modulo DEPTH
//   - ovf stays 1 until reset or clear
//  Clear
//   - clear=1 at an edge: bit_idx, pointers, fill, match_total and ovf go to 0
//   - clear overrides push/pop on that edge; the coincident detection is not logged/counted
//  Reset mid-operation: async assertion empties the FIFO at once; evt_valid drops without a clock
// TESTING
//  T1 reset low, toggle clk -> all outputs 0; release, 3 idle clocks -> evt_valid=0, fill=0
//  T2 bit_en=1 for 8 bits, z=1 on bits 3 and 5 (idx) -> evt_pos 3 then 5; match_total=2
//  T3 evt_ready=0, 5 matches with DEPTH=4 -> fill=4, ovf=1, match_total=5; drain -> first 4 idx in order
//  T4 full FIFO, push & evt_ready same edge -> fill=4, ovf stays 0, oldest popped, new at tail
//  T5 z=1 with bit_en=0 -> no push, bit_idx unchanged; 256 bit_en cycles (CNT_W=8) -> idx wraps to 0
//  T6 clear asserted with a coincident push -> fill=0, match_total=0, ovf=0; async reset mid-drain -> evt_valid 0 before next edge

Source files
------------

// File: rtl/seq_match_logger.sv
// Logs the bit index of each detector match into a show-ahead FIFO, with saturating match count and sticky overflow.
// Latency: a match at edge N is visible on o_evt_valid/o_evt_pos right after edge N.
// Backpressure: o_evt_valid/i_evt_ready drain; a match arriving when full with no pop is dropped and sets o_ovf.
module seq_match_logger #(
    parameter  int CNT_W   = 8,
    parameter  int DEPTH   = 4,
    parameter  int MATCH_W = 16,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_bit_en,
    input  logic               i_z,
    input  logic               i_evt_ready,
    output logic               o_evt_valid,
    output logic [CNT_W-1:0]   o_evt_pos,
    output logic [ADDR_W:0]    o_fill,
    output logic [MATCH_W-1:0] o_match_total,
    output logic               o_ovf
);

    logic [CNT_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W:0]    r_fill;
    logic [CNT_W-1:0]   r_bit_idx;
    logic [MATCH_W-1:0] r_match_total;
    logic               r_ovf;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr_ok;

    assign w_push  = i_z & i_bit_en;
    assign w_pop   = o_evt_valid & i_evt_ready;
    assign w_full  = (r_fill == (ADDR_W+1)'(DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_wr_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_bit_idx <= '0;
        end else if (i_clear) begin
            r_bit_idx <= '0;
        end else if (i_bit_en) begin
            r_bit_idx <= r_bit_idx + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
        end else if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= r_bit_idx;
            r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fill <= '0;
        end else if (i_clear) begin
            r_fill <= '0;
        end else begin
            case ({w_wr_ok, w_pop})
                2'b10:   r_fill <= r_fill + (ADDR_W+1)'(1);
                2'b01:   r_fill <= r_fill - (ADDR_W+1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_match_total <= '0;
            r_ovf         <= 1'b0;
        end else if (i_clear) begin
            r_match_total <= '0;
            r_ovf         <= 1'b0;
        end else begin
            if (w_push && (r_match_total != {MATCH_W{1'b1}})) begin
                r_match_total <= r_match_total + MATCH_W'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_evt_valid   = (r_fill != '0);
    assign o_evt_pos     = o_evt_valid ? r_mem[r_rd_ptr] : '0;
    assign o_fill        = r_fill;
    assign o_match_total = r_match_total;
    assign o_ovf         = r_ovf;

endmodule

// File: tb/tb_seq_match_logger.sv
// Bench for seq_match_logger: directed scenarios plus random traffic against a queue-based reference model.
module tb_seq_match_logger;

    localparam int CNT_W   = 8;
    localparam int DEPTH   = 4;
    localparam int MATCH_W = 16;
    localparam int ADDR_W  = $clog2(DEPTH);

    logic               clk;
    logic               reset;
    logic               clear;
    logic               bit_en;
    logic               z;
    logic               evt_ready;
    logic               evt_valid;
    logic [CNT_W-1:0]   evt_pos;
    logic [ADDR_W:0]    fill;
    logic [MATCH_W-1:0] match_total;
    logic               ovf;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of logged indices plus scalar counters.
    int m_q[$];
    int m_idx   = 0;
    int m_total = 0;
    bit m_ovf   = 1'b0;

    seq_match_logger #(.CNT_W(CNT_W), .DEPTH(DEPTH), .MATCH_W(MATCH_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_clear       (clear),
        .i_bit_en      (bit_en),
        .i_z           (z),
        .i_evt_ready   (evt_ready),
        .o_evt_valid   (evt_valid),
        .o_evt_pos     (evt_pos),
        .o_fill        (fill),
        .o_match_total (match_total),
        .o_ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_idx   = 0;
        m_total = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic be, input logic zz, input logic rdy, input logic clr);
        bit did_pop;
        if (clr) begin
            model_reset();
            return;
        end
        did_pop = (m_q.size() > 0) && rdy;
        if (did_pop) void'(m_q.pop_front());
        if (be && zz) begin
            if (m_total < (1 << MATCH_W) - 1) m_total++;
            if (m_q.size() < DEPTH) m_q.push_back(m_idx);
            else m_ovf = 1'b1;
        end
        if (be) m_idx = (m_idx + 1) % (1 << CNT_W);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() != 0));
        check({tag, ".fill"},  32'(fill), 32'(m_q.size()));
        check({tag, ".total"}, 32'(match_total), 32'(m_total));
        check({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
        if (m_q.size() != 0) check({tag, ".pos"}, 32'(evt_pos), 32'(m_q[0]));
    endtask

    task automatic step(input string tag, input logic be, input logic zz, input logic rdy, input logic clr);
        @(negedge clk);
        bit_en    = be;
        z         = zz;
        evt_ready = rdy;
        clear     = clr;
        @(posedge clk);
        model_edge(be, zz, rdy, clr);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        bit_en    = 1'b0;
        z         = 1'b0;
        evt_ready = 1'b0;

        // T1: reset held low while clocking, then idle after release
        repeat (3) @(posedge clk);
        #1;
        check("t1.valid", 32'(evt_valid), 0);
        check("t1.pos",   32'(evt_pos), 0);
        check("t1.fill",  32'(fill), 0);
        check("t1.total", 32'(match_total), 0);
        check("t1.ovf",   32'(ovf), 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // T2: 8 bits, matches on indices 3 and 5
        for (int i = 0; i < 8; i++) step("t2", 1'b1, (i == 3 || i == 5), 1'b0, 1'b0);
        check("t2.head3", 32'(evt_pos), 3);
        check("t2.total", 32'(match_total), 2);
        step("t2.pop", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t2.head5", 32'(evt_pos), 5);
        step("t2.pop", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t2.empty", 32'(evt_valid), 0);

        // T3: overflow with no consumer, then drain in order
        step("t3.clr", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("t3.push", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t3.fill",  32'(fill), 4);
        check("t3.ovf",   32'(ovf), 1);
        check("t3.total", 32'(match_total), 5);
        for (int i = 0; i < 4; i++) begin
            check("t3.drain", 32'(evt_pos), 32'(i));
            step("t3.pop", 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("t3.ovf_sticky", 32'(ovf), 1);

        // T4: full FIFO, push and pop on the same edge
        step("t4.clr", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("t4.fill", 1'b1, 1'b1, 1'b0, 1'b0);
        step("t4.both", 1'b1, 1'b1, 1'b1, 1'b0);
        check("t4.fill", 32'(fill), 4);
        check("t4.ovf",  32'(ovf), 0);
        check("t4.head", 32'(evt_pos), 1);
        for (int i = 1; i <= 4; i++) begin
            check("t4.order", 32'(evt_pos), 32'(i));
            step("t4.pop", 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // T5: z without bit_en is ignored; index wraps after 256 bits
        step("t5.clr", 1'b0, 1'b0, 1'b0, 1'b1);
        step("t5.nobit", 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5.nopush", 32'(fill), 0);
        for (int i = 0; i < 256; i++) step("t5.run", 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5.wrap", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t5.wrappos", 32'(evt_pos), 0);
        step("t5.next", 1'b1, 1'b1, 1'b0, 1'b0);
        step("t5.pop", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5.nextpos", 32'(evt_pos), 1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 9) < 4),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 49) == 0));
        end

        // T6: clear with a coincident detection, then async reset mid-drain
        step("t6.pre", 1'b1, 1'b1, 1'b0, 1'b0);
        step("t6.pre", 1'b1, 1'b1, 1'b0, 1'b0);
        step("t6.clr", 1'b1, 1'b1, 1'b0, 1'b1);
        check("t6.fill",  32'(fill), 0);
        check("t6.total", 32'(match_total), 0);
        check("t6.ovf",   32'(ovf), 0);
        for (int i = 0; i < 3; i++) step("t6.push", 1'b1, 1'b1, 1'b0, 1'b0);
        step("t6.pop", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6.predrain", 32'(fill), 2);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("t6.async_valid", 32'(evt_valid), 0);
        check("t6.async_fill",  32'(fill), 0);
        check("t6.async_total", 32'(match_total), 0);
        @(negedge clk);
        reset = 1'b1;
        step("t6.after", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t6.after_pos", 32'(evt_pos), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
